// File: rtl/prog_mem_loader_pkg.sv
// rtl/prog_mem_loader_pkg.sv - shared widths, framing constants and loader state encodings
package prog_mem_loader_pkg;

  localparam int PM_ADDR_W      = 8;
  localparam int PM_WORD_W      = 16;
  localparam int BYTES_PER_WORD = 2;
  localparam int CHK_MODULUS    = 256;

  typedef logic [2:0] state_t;

  localparam state_t ST_WAIT_LEN = 3'd0;
  localparam state_t ST_RX_HI    = 3'd1;
  localparam state_t ST_RX_LO    = 3'd2;
  localparam state_t ST_WRITE    = 3'd3;
  localparam state_t ST_RX_CHK   = 3'd4;
  localparam state_t ST_DONE     = 3'd5;
  localparam state_t ST_ERROR    = 3'd6;

endpackage

// File: rtl/prog_mem_loader_if.sv
// rtl/prog_mem_loader_if.sv - byte-stream input and program-memory write port of the loader
interface prog_mem_loader_if
  import prog_mem_loader_pkg::*;
#(
  parameter int ADDR_W = PM_ADDR_W,
  parameter int WORD_W = PM_WORD_W
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              pm_we;
  logic [ADDR_W-1:0] pm_addr;
  logic [WORD_W-1:0] pm_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, pm_we, pm_addr, pm_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, pm_we, pm_addr, pm_wdata
  );

endinterface

// File: rtl/prog_mem_loader_csum.sv
// rtl/prog_mem_loader_csum.sv - 8-bit running checksum; used only with PROG_MEM_LOADER_CHECKSUM_EN
module prog_mem_loader_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_byte,
  output logic       o_sum_zero
);

  logic [7:0] r_acc;
  logic [7:0] w_sum;

  // The 8-bit adder wraps, which is exactly the mod-256 frame rule.
  assign w_sum      = r_acc + i_byte;
  assign o_sum_zero = (w_sum == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 8'd0;
    end else if (i_clr) begin
      r_acc <= 8'd0;
    end else if (i_add) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - byte-stream program-memory loader; checksum option PROG_MEM_LOADER_CHECKSUM_EN
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int ADDR_W = PM_ADDR_W,
  parameter int WORD_W = PM_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  prog_mem_loader_if.slave  bus,
  input  logic              restart,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int WC_W = ADDR_W + 1;

  state_t            r_state;
  logic [7:0]        r_len;
  logic [7:0]        r_hi;
  logic [ADDR_W-1:0] r_pm_addr;
  logic [WORD_W-1:0] r_pm_wdata;
  logic [WC_W-1:0]   r_word_count;

  logic              w_xfer;
  logic [WC_W-1:0]   w_wc_next;
  logic [WC_W-1:0]   w_len_words;

  assign bus.in_ready = (r_state == ST_WAIT_LEN) || (r_state == ST_RX_HI) ||
                        (r_state == ST_RX_LO)    || (r_state == ST_RX_CHK);
  assign w_xfer       = bus.in_valid && bus.in_ready;
  assign w_wc_next    = r_word_count + 1'b1;
  // LEN=0 encodes a full memory image.
  assign w_len_words  = (r_len == 8'd0) ? WC_W'(1 << ADDR_W) : WC_W'(r_len);

  assign bus.pm_we    = (r_state == ST_WRITE);
  assign bus.pm_addr  = r_pm_addr;
  assign bus.pm_wdata = r_pm_wdata;
  assign word_count   = r_word_count;
  assign done         = (r_state == ST_DONE);
  assign core_hold    = (r_state != ST_DONE);

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
  logic w_sum_zero;

  prog_mem_loader_csum u_csum (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_xfer && (r_state == ST_WAIT_LEN)),
    .i_add      (w_xfer && ((r_state == ST_RX_HI) || (r_state == ST_RX_LO))),
    .i_byte     (bus.in_data),
    .o_sum_zero (w_sum_zero)
  );

  assign err = (r_state == ST_ERROR);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_WAIT_LEN;
      r_len        <= 8'd0;
      r_hi         <= 8'd0;
      r_pm_addr    <= '0;
      r_pm_wdata   <= '0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        ST_WAIT_LEN: if (w_xfer) begin
          r_len        <= bus.in_data;
          r_pm_addr    <= '0;
          r_word_count <= '0;
          r_state      <= ST_RX_HI;
        end
        ST_RX_HI: if (w_xfer) begin
          r_hi    <= bus.in_data;
          r_state <= ST_RX_LO;
        end
        ST_RX_LO: if (w_xfer) begin
          r_pm_wdata <= {r_hi, bus.in_data};
          r_state    <= ST_WRITE;
        end
        ST_WRITE: begin
          r_word_count <= w_wc_next;
          // The address stays on the last word written once the frame is complete.
          if (w_wc_next == w_len_words) begin
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
            r_state <= ST_RX_CHK;
`else
            r_state <= ST_DONE;
`endif
          end else begin
            r_pm_addr <= r_pm_addr + 1'b1;
            r_state   <= ST_RX_HI;
          end
        end
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        ST_RX_CHK: if (w_xfer) begin
          r_state <= w_sum_zero ? ST_DONE : ST_ERROR;
        end
`endif
        ST_DONE, ST_ERROR: if (restart) begin
          r_state <= ST_WAIT_LEN;
        end
        default: r_state <= ST_WAIT_LEN;
      endcase
    end
  end

endmodule
